// File: rtl/seg_scan_pkg.sv
// Shared display constants and types for the seven-segment path (BCD decoder and scanner).
package seg_scan_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam int         PHASES    = 16;
  localparam int         DIGITS    = 4;

  typedef logic [6:0] seg_t;

  // Active-low digit enable with only the selected digit driven low.
  function automatic logic [3:0] an_sel(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction
endpackage

// File: rtl/seg_scan_if.sv
// Digit patterns and brightness in, multiplexed segment/anode bus and frame pulse out.
interface seg_scan_if;
  import seg_scan_pkg::*;

  seg_t       seg_uni;
  seg_t       seg_dec;
  seg_t       seg_cen;
  seg_t       seg_mil;
  logic [3:0] duty;
  seg_t       seg;
  logic [3:0] an;
  logic       frame_tick;

  modport slave (
    input  seg_uni, seg_dec, seg_cen, seg_mil, duty,
    output seg, an, frame_tick
  );

  modport master (
    output seg_uni, seg_dec, seg_cen, seg_mil, duty,
    input  seg, an, frame_tick
  );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: free-running 0..DIV-1 counter, tick high for the single cycle at DIV-1.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner with per-frame snapshot and phase-based PWM brightness.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);
  logic       w_tick;
  logic       w_lit;
  logic       w_frame_end;
  logic       w_snap_load;
  logic [3:0] r_phase;
  logic [1:0] r_digit;
  seg_t       r_snap [DIGITS];
  seg_t       r_seg;
  logic [3:0] r_an;
  logic       r_frame;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  // Phase 0 is always dark so the previous digit's pattern never ghosts onto the next anode.
  assign w_lit       = (r_phase != 4'd0) && (r_phase <= bus.duty);
  assign w_frame_end = w_tick && (r_phase == 4'(PHASES - 1)) && (r_digit == 2'(DIGITS - 1));
  assign w_snap_load = (r_digit == 2'd0) && (r_phase == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_digit <= '0;
    end else if (w_tick) begin
      r_phase <= r_phase + 4'd1;
      if (r_phase == 4'(PHASES - 1)) r_digit <= r_digit + 2'd1;
    end
  end

  // Content is frozen for the whole frame; inputs only land during digit 0, phase 0 (always dark).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) r_snap[i] <= SEG_BLANK;
    end else if (w_snap_load) begin
      r_snap[0] <= bus.seg_uni;
      r_snap[1] <= bus.seg_dec;
      r_snap[2] <= bus.seg_cen;
      r_snap[3] <= bus.seg_mil;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= SEG_BLANK;
      r_an    <= AN_OFF;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_lit ? r_snap[r_digit] : SEG_BLANK;
      r_an    <= w_lit ? an_sel(r_digit) : AN_OFF;
      r_frame <= w_frame_end;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame;
endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: driver pushes per-cycle expectations from a timeline model, monitor compares.
module tb_seg_scan;
  import seg_scan_pkg::*;

  localparam int DIV   = 4;
  localparam int SLOT  = 16 * DIV;
  localparam int FRAME = 64 * DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg_scan_if bus ();

  seg_scan #(.DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  logic [27:0] hist [4096];
  int          cyc    = 0;
  int          checks = 0;
  int          fails  = 0;
  logic        ft_prev = 1'b0;

  // Expected outputs after the k-th clock edge since reset release, from the timeline rules:
  // phase = which DIV-cycle block within the slot, digit = which slot within the frame,
  // content = inputs present on the last cycle of the frame's first phase.
  function automatic exp_t model(input int k, input logic [3:0] du);
    exp_t        e;
    int          phase, digit, fs;
    logic [27:0] snap;
    phase = (k / DIV) % 16;
    digit = (k / SLOT) % 4;
    fs    = k - (k % FRAME);
    snap  = hist[fs + DIV - 1];
    e.seg = 7'h7F;
    e.an  = 4'hF;
    e.ft  = ((k % FRAME) == FRAME - 1);
    if (phase >= 1 && phase <= int'(du)) begin
      e.seg       = snap[digit*7 +: 7];
      e.an[digit] = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input logic rn, input logic [6:0] u, input logic [6:0] d,
                       input logic [6:0] c, input logic [6:0] m, input logic [3:0] du);
    exp_t e;
    @(negedge clk);
    bus.seg_uni = u;
    bus.seg_dec = d;
    bus.seg_cen = c;
    bus.seg_mil = m;
    bus.duty    = du;
    if (!rn) begin
      if (rst_n) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.frame_tick !== 1'b0) begin
          fails++;
          $display("FAIL async_reset_blank: got an=%b seg=%h ft=%b, want an=1111 seg=7f ft=0",
                   bus.an, bus.seg, bus.frame_tick);
        end
      end
      cyc = 0;
      e   = '{seg: 7'h7F, an: 4'hF, ft: 1'b0};
    end else begin
      rst_n     = 1'b1;
      hist[cyc] = {m, c, d, u};
      e         = model(cyc, du);
      cyc++;
    end
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({bus.seg, bus.an, bus.frame_tick} !== e) begin
        fails++;
        $display("FAIL scan_out t=%0t: got seg=%h an=%b ft=%b, want seg=%h an=%b ft=%b",
                 $time, bus.seg, bus.an, bus.frame_tick, e.seg, e.an, e.ft);
      end
    end
  end

  // Whole-run invariant: anodes one-hot-low or all off, frame pulse never two cycles wide.
  always @(posedge clk) begin
    #2;
    checks++;
    if (!(bus.an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}) || (bus.frame_tick && ft_prev)) begin
      fails++;
      $display("FAIL invariant t=%0t: got an=%b ft=%b prev_ft=%b, want one-hot-low/1111 and no double pulse",
               $time, bus.an, bus.frame_tick, ft_prev);
    end
    ft_prev = bus.frame_tick;
  end

  initial begin
    logic [6:0] u, d, c, m;
    bus.seg_uni = 7'h40;
    bus.seg_dec = 7'h79;
    bus.seg_cen = 7'h24;
    bus.seg_mil = 7'h30;
    bus.duty    = 4'd15;
    #1 rst_n = 1'b0;

    for (int i = 0; i < 3; i++) drive(1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'd15);
    // Fixed digits at full brightness, then dark, then dim.
    for (int i = 0; i < FRAME; i++)     drive(1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'd15);
    for (int i = 0; i < 2 * FRAME; i++) drive(1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'd0);
    for (int i = 0; i < FRAME; i++)     drive(1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'd3);
    // Hundreds pattern changes during digit 1; must not show until the following frame.
    for (int i = 0; i < FRAME; i++)
      drive(1'b1, 7'h40, 7'h79, (i >= SLOT + 16) ? 7'h12 : 7'h24, 7'h30, 4'd15);
    for (int i = 0; i < FRAME; i++)     drive(1'b1, 7'h40, 7'h79, 7'h12, 7'h30, 4'd15);
    for (int i = 0; i < 4 * FRAME; i++) begin
      u = 7'($urandom); d = 7'($urandom); c = 7'($urandom); m = 7'($urandom);
      drive(1'b1, u, d, c, m, 4'($urandom_range(0, 15)));
    end
    // Reset lands at digit 2, phase 7 of the next frame while that digit is lit.
    for (int i = 0; i < 2 * SLOT + 7 * DIV + 2; i++) begin
      u = 7'($urandom); d = 7'($urandom); c = 7'($urandom); m = 7'($urandom);
      drive(1'b1, u, d, c, m, 4'd15);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'd15);
    for (int i = 0; i < 2 * FRAME; i++) begin
      u = 7'($urandom); d = 7'($urandom); c = 7'($urandom); m = 7'($urandom);
      drive(1'b1, u, d, c, m, 4'($urandom_range(0, 15)));
    end

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clock cycles per scan phase; legal range is DIV >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state is on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port seg_uni, input, 7 bits, the units digit segment pattern from the BCD decoder (active-low, bit0 = segment a).
REQ-005 The block SHALL have port seg_dec, input, 7 bits, the tens digit pattern, same encoding as seg_uni.
REQ-006 The block SHALL have port seg_cen, input, 7 bits, the hundreds digit pattern, same encoding as seg_uni.
REQ-007 The block SHALL have port seg_mil, input, 7 bits, the thousands digit pattern, same encoding as seg_uni.
REQ-008 The block SHALL have port duty, input, 4 bits, the brightness level, 0 = dark and 15 = maximum.
REQ-009 The block SHALL have port seg, output, 7 bits, the shared segment bus (active-low).
REQ-010 The block SHALL have port an, output, 4 bits, the digit enables (active-low): an[0] = units ... an[3] = thousands.
REQ-011 The block SHALL have port frame_tick, output, 1 bit, a one-cycle pulse at each frame boundary.

Function
REQ-012 A prescaler SHALL assert an internal tick for one cycle every DIV clocks; its counter runs 0..DIV-1 and wraps.
REQ-013 On each tick, a 4-bit phase counter SHALL advance and wrap 15->0.
REQ-014 When phase wraps 15->0, a 2-bit digit counter SHALL advance and wrap 3->0.
REQ-015 Consequently, one digit slot SHALL be 16*DIV cycles and one frame SHALL be 64*DIV cycles.
REQ-016 A snapshot register set (4x7 bits) SHALL load all four seg_* inputs on every clock where digit==0 and phase==0; at all other times it holds.
REQ-017 Because of REQ-016, display content SHALL change only at frame start, so input changes mid-frame never tear.
REQ-018 The digit is lit when phase >= 1 and phase <= duty.
REQ-019 Phase 0 SHALL always be dark (anti-ghosting gap).
REQ-020 duty = 0 SHALL keep all digits dark.
REQ-021 duty = 15 SHALL light phases 1..15.
REQ-022 duty SHALL be sampled live each cycle; it is not snapshotted.
REQ-023 When lit, an SHALL drive the bit of the current digit low and the other three bits high, and seg SHALL carry that digit's snapshot pattern.
REQ-024 When dark, an SHALL be 4'hF and seg SHALL be 7'h7F.
REQ-025 seg and an SHALL be registered outputs: they reflect counter state with exactly one clock of latency.
REQ-026 an SHALL never have more than one bit low in any cycle.
REQ-027 frame_tick SHALL pulse high for exactly one cycle, in the cycle after the tick at which digit wraps 3->0, aligned with the registered outputs.
REQ-028 No input combination SHALL stall or reorder the scan; the scan order is strictly 0,1,2,3,0,...

Reset
REQ-029 While rst_n is low, the prescaler, phase and digit counters SHALL be 0.
REQ-030 While rst_n is low, the snapshot registers SHALL be 7'h7F, seg SHALL be 7'h7F, an SHALL be 4'hF and frame_tick SHALL be 0.
REQ-031 Reset asserted mid-slot SHALL blank the outputs immediately (asynchronous).
REQ-032 After release, the scan SHALL restart at digit 0, phase 0, and the snapshot SHALL load on the first clock after release.

Structure
REQ-033 A shared header SHALL define SEG_BLANK = 7'h7F, AN_OFF = 4'hF and PHASES = 16; the bcd decoder path and this block SHALL both use it.
REQ-034 The prescaler SHALL be a sub-module tick_gen (parameter DIV; ports clk, rst_n, tick).
REQ-035 The phase/digit counters, snapshot and output registers SHALL live in seg_scan.

Verification (DIV = 4: slot = 64 cycles, frame = 256 cycles)
REQ-036 Reset then hold seg_uni=7'h40, seg_dec=7'h79, seg_cen=7'h24, seg_mil=7'h30, duty=15 -> an cycles 1110, 1101, 1011, 0111 with the matching seg; each digit is lit 60 of 64 cycles; seg=7'h7F during phase 0.
REQ-037 duty=0 for 2 frames -> an=4'hF and seg=7'h7F throughout; frame_tick still pulses every 256 cycles.
REQ-038 duty=3 -> each digit is lit 12 cycles per slot (phases 1-3), and dark for the remaining 52 cycles.
REQ-039 Change seg_cen to 7'h12 mid-frame (during digit 1) -> digit 2 still shows 7'h24 in that frame; 7'h12 first appears in the next frame.
REQ-040 Assert rst_n low during digit 2, phase 7 -> an=4'hF asynchronously; after release, digit 0 is scanned first and frame_tick stays low for the first 255 cycles.
REQ-041 An assertion SHALL run for the whole simulation: an is always one-hot-low or 4'hF, and frame_tick is never high on two consecutive cycles.
